// File: rtl/irq_ctrl.sv
// irq_ctrl: interrupt sequencer in front of the CSR unit.
// Synchronises the raw interrupt lines, latches rising edges as pending
// requests, stops fetch and drains the pipeline, then raises a one-cycle
// one-hot trap request. Further interrupts are held off until mret.
module irq_ctrl #(
  parameter int SYNC_STAGES  = 2,  // flops per synchroniser chain (2..4)
  parameter int DRAIN_CYCLES = 3,  // minimum stopped cycles before the trap (1..15)
  parameter int CNT_W        = 4   // drain counter width, must hold DRAIN_CYCLES
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] ext_irq,      // bit1 = timer, bit0 = external
  input  logic       mie_bit,
  input  logic       pipe_busy,
  input  logic       jump,
  input  logic       mret,
  output logic       stop_fetch,
  output logic [1:0] interrupt_o,
  output logic       in_handler,
  output logic [1:0] pending
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DRAIN   = 2'd1,
    TRAP    = 2'd2,
    HANDLER = 2'd3
  } state_t;

  state_t           state;
  state_t           state_nxt;

  logic [1:0]       sync_q [SYNC_STAGES];
  logic [1:0]       hist_q;
  logic [1:0]       rise;
  logic [1:0]       grant;
  logic [1:0]       clr;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_dec;
  logic             drain_done;

  // Synchroniser chains plus one history flop for rising-edge detection.
  // NOTE: the synchroniser array is reset element by element so the edge
  // detector cannot report a spurious rising edge straight out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
      hist_q <= '0;
    end else begin
      // NOTE: non-blocking assignments let every stage sample the previous
      // stage's old value, so the chain shifts by exactly one per edge.
      sync_q[0] <= ext_irq;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise = sync_q[SYNC_STAGES-1] & ~hist_q;

  // Fixed priority: the timer line (bit1) wins over the external line (bit0).
  always_comb begin
    // NOTE: defaulting every output first keeps this block purely
    // combinational; a missing branch would otherwise infer a latch.
    grant = 2'b00;
    if (pending[1]) begin
      grant = 2'b10;
    end else if (pending[0]) begin
      grant = 2'b01;
    end
  end

  // Only the line being serviced is cleared, and only in the trap cycle.
  assign clr = (state == TRAP) ? grant : 2'b00;

  // Pending latch: a new edge on the same cycle as the clear wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending <= '0;
    end else begin
      pending <= (pending & ~clr) | rise;
    end
  end

  // The counter holds the drain cycles remaining including the current one;
  // once the decremented value reaches zero the minimum drain time is met.
  assign cnt_dec    = (cnt == '0) ? '0 : cnt - CNT_W'(1);
  assign drain_done = (cnt_dec == '0);

  // Drain counter: reloaded while idle, counts down to zero in DRAIN.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (state == IDLE) begin
      cnt <= CNT_W'(DRAIN_CYCLES);
    end else if (state == DRAIN) begin
      cnt <= cnt_dec;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; a cleared MIE aborts the drain ahead of the trap.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if ((|pending) && mie_bit) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (!mie_bit) begin
          state_nxt = IDLE;
        end else if (drain_done && !pipe_busy && !jump) begin
          state_nxt = TRAP;
        end
      end
      TRAP: begin
        state_nxt = HANDLER;
      end
      HANDLER: begin
        if (mret) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Registered status outputs, updated on the same edge as the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stop_fetch <= 1'b0;
      in_handler <= 1'b0;
    end else begin
      stop_fetch <= (state_nxt == DRAIN) || (state_nxt == TRAP);
      in_handler <= (state_nxt == HANDLER);
    end
  end

  // Trap request is decoded from registers only, so it is never driven
  // from the raw interrupt lines and is zero outside the trap cycle.
  assign interrupt_o = (state == TRAP) ? grant : 2'b00;

endmodule

// File: tb/tb_irq_ctrl.sv
// Self-checking bench for irq_ctrl: directed scenarios followed by random
// stimulus, every cycle compared against a behavioural model.
module tb_irq_ctrl;

  localparam int S  = 2;
  localparam int DC = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] ext_irq;
  logic       mie_bit;
  logic       pipe_busy;
  logic       jump;
  logic       mret;
  logic       stop_fetch;
  logic [1:0] interrupt_o;
  logic       in_handler;
  logic [1:0] pending;

  int checks = 0;
  int errors = 0;

  irq_ctrl #(.SYNC_STAGES(S), .DRAIN_CYCLES(DC), .CNT_W(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .ext_irq     (ext_irq),
    .mie_bit     (mie_bit),
    .pipe_busy   (pipe_busy),
    .jump        (jump),
    .mret        (mret),
    .stop_fetch  (stop_fetch),
    .interrupt_o (interrupt_o),
    .in_handler  (in_handler),
    .pending     (pending)
  );

  always #5 clk = ~clk;

  // Behavioural model: raw samples of ext_irq from past edges, a pending
  // word, and flags for "fetch stopped", "trap firing" and "in service".
  logic [1:0] m_hist [S+1];
  logic [1:0] m_pend;
  bit         m_stop;
  bit         m_fire;
  bit         m_serv;
  int         m_stopped_for;

  function automatic logic [1:0] highest(input logic [1:0] p);
    if (p[1]) return 2'b10;
    if (p[0]) return 2'b01;
    return 2'b00;
  endfunction

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int j = 0; j <= S; j++) m_hist[j] = 2'b00;
    m_pend        = 2'b00;
    m_stop        = 0;
    m_fire        = 0;
    m_serv        = 0;
    m_stopped_for = 0;
  endtask

  // One clock edge of the model, using the inputs present at that edge.
  task automatic model_edge();
    logic [1:0] rise_m;
    logic [1:0] taken;
    rise_m = m_hist[S-1] & ~m_hist[S];
    for (int j = S; j > 0; j--) m_hist[j] = m_hist[j-1];
    m_hist[0] = ext_irq;
    taken  = m_fire ? highest(m_pend) : 2'b00;
    if (m_fire) begin
      m_fire = 0;
      m_serv = 1;
    end else if (m_serv) begin
      if (mret) m_serv = 0;
    end else if (m_stop) begin
      m_stopped_for++;
      if (!mie_bit) begin
        m_stop = 0;
      end else if (m_stopped_for >= DC && !pipe_busy && !jump) begin
        m_stop = 0;
        m_fire = 1;
      end
    end else if (m_pend != 2'b00 && mie_bit) begin
      m_stop        = 1;
      m_stopped_for = 0;
    end
    m_pend = (m_pend & ~taken) | rise_m;
  endtask

  task automatic compare_all();
    check("stop_fetch",  {7'd0, stop_fetch}, {7'd0, m_stop | m_fire});
    check("interrupt_o", {6'd0, interrupt_o}, {6'd0, (m_fire ? highest(m_pend) : 2'b00)});
    check("in_handler",  {7'd0, in_handler}, {7'd0, m_serv});
    check("pending",     {6'd0, pending}, {6'd0, m_pend});
    check("onehot",      {7'd0, ($countones(interrupt_o) <= 1)}, 8'd1);
  endtask

  task automatic tick(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      if (rst) model_reset();
      else     model_edge();
      @(negedge clk);
      compare_all();
    end
  endtask

  task automatic pulse(input logic [1:0] b);
    ext_irq = b;
    tick(2);
    ext_irq = 2'b00;
  endtask

  task automatic pulse_mret();
    mret = 1'b1;
    tick();
    mret = 1'b0;
  endtask

  // Assert reset between clock edges and check outputs clear without an edge.
  task automatic async_reset();
    #2;
    rst = 1'b1;
    #1;
    check("rst_stop",    {7'd0, stop_fetch}, 8'd0);
    check("rst_irq",     {6'd0, interrupt_o}, 8'd0);
    check("rst_handler", {7'd0, in_handler}, 8'd0);
    check("rst_pending", {6'd0, pending}, 8'd0);
    model_reset();
    @(negedge clk);
    tick(2);
    rst = 1'b0;
    tick();
  endtask

  initial begin
    rst       = 1'b1;
    ext_irq   = 2'b00;
    mie_bit   = 1'b1;
    pipe_busy = 1'b0;
    jump      = 1'b0;
    mret      = 1'b0;
    model_reset();
    @(negedge clk);
    tick(2);
    rst = 1'b0;
    tick(2);

    // Single external interrupt through drain, trap and mret.
    pulse(2'b01);
    tick(10);
    pulse_mret();
    tick(3);

    // Both lines together: timer first, external after mret.
    pulse(2'b11);
    tick(10);
    pulse_mret();
    tick(10);
    pulse_mret();
    tick(3);

    // Pipeline busy for 8 drain cycles, jump on the cycle busy falls.
    pipe_busy = 1'b1;
    pulse(2'b01);
    tick(2);
    tick(7);
    pipe_busy = 1'b0;
    jump      = 1'b1;
    tick();
    jump      = 1'b0;
    tick(3);
    pulse_mret();
    tick(3);

    // MIE cleared during drain, then restored.
    pulse(2'b01);
    tick(3);
    mie_bit = 1'b0;
    tick(3);
    mie_bit = 1'b1;
    tick(8);
    pulse_mret();
    tick(3);

    // New timer edge while in the handler is held until mret.
    pulse(2'b01);
    tick(8);
    pulse(2'b10);
    tick(8);
    pulse_mret();
    tick(10);
    pulse_mret();
    tick(3);

    // Reset in the middle of a drain.
    pulse(2'b01);
    tick(3);
    async_reset();
    tick(6);

    // Random traffic.
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 7) == 0) begin
        if ($urandom_range(0, 1) == 0) ext_irq[0] = ~ext_irq[0];
        else                           ext_irq[1] = ~ext_irq[1];
      end
      mie_bit   = ($urandom_range(0, 15) != 0);
      pipe_busy = ($urandom_range(0, 2) == 0);
      jump      = ($urandom_range(0, 3) == 0);
      mret      = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 499) == 0) async_reset();
      else                             tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
